mem_copy_engine: RTL and testbench

Block-transfer initiator that drives the single-pointer data memory's port (address, write enable, write data) and consumes its combinational read data. It copies a block of bytes from a source address to a destination address, or fills a block with a constant. It sits beside the processor core; a top-level mux hands the memory port to this block while Busy is high.

---
 rtl/mem_dma_pkg.sv | 22 ++
 rtl/mem_copy_engine.sv | 132 +++++++++++++
 tb/tb_mem_copy_engine.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// Shared types and default widths for the block-transfer initiator.
//   DMA_ADDR_W / DMA_DATA_W : default memory address / data widths
//   dma_state_t             : transfer FSM states
//   dma_mode_t              : copy or fill
package mem_dma_pkg;

    localparam int DMA_ADDR_W = 8;
    localparam int DMA_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } dma_mode_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-transfer initiator: copies Len bytes from SrcAddr to DstAddr, or fills
// Len bytes at DstAddr with FillValue, by driving the data-memory port while
// Busy is high.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   Start, Mode         transfer request (IDLE only), 0 = copy / 1 = fill
//   SrcAddr, DstAddr    first source / destination address
//   Len                 byte count (0 = no transfer)
//   FillValue           constant written in fill mode
//   MemAddress, MemWriteEn, MemDataIn   memory port outputs
//   MemDataOut          combinational memory read data
//   Busy, Done          transfer in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for Start; memory port parked at zero
// READ  | source byte on the bus, captured into hold_r at the edge
// WRITE | destination write of hold_r (copy) or fill_r (fill)
// DONE  | one-cycle Done pulse, Start ignored
module mem_copy_engine
    import mem_dma_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [ADDR_W-1:0] Len,
    input  logic [DATA_W-1:0] FillValue,
    output logic [ADDR_W-1:0] MemAddress,
    output logic              MemWriteEn,
    output logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] MemDataOut,
    output logic              Busy,
    output logic              Done
);

    dma_state_t        state;
    dma_state_t        next_state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] remaining;
    dma_mode_t         mode_r;
    logic [DATA_W-1:0] fill_r;
    logic [DATA_W-1:0] hold_r;

    // Memory outputs depend only on state and registers, so nothing on the
    // input ports can reach the memory combinationally; the async reset of
    // state is what drops MemWriteEn immediately.
    always_comb begin
        next_state = state;
        MemAddress = '0;
        MemWriteEn = 1'b0;
        MemDataIn  = '0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Len == '0)
                        next_state = DONE;
                    else if (dma_mode_t'(Mode) == MODE_FILL)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ: begin
                Busy       = 1'b1;
                MemAddress = src_ptr;
                next_state = WRITE;
            end
            WRITE: begin
                Busy       = 1'b1;
                MemAddress = dst_ptr;
                MemWriteEn = 1'b1;
                MemDataIn  = (mode_r == MODE_FILL) ? fill_r : hold_r;
                if (remaining == ADDR_W'(1))
                    next_state = DONE;
                else if (mode_r == MODE_FILL)
                    next_state = WRITE;
                else
                    next_state = READ;
            end
            DONE: begin
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            mode_r    <= MODE_COPY;
            fill_r    <= '0;
            hold_r    <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (Start) begin
                        src_ptr   <= SrcAddr;
                        dst_ptr   <= DstAddr;
                        remaining <= Len;
                        mode_r    <= dma_mode_t'(Mode);
                        fill_r    <= FillValue;
                    end
                end
                READ: begin
                    hold_r  <= MemDataOut;
                    src_ptr <= src_ptr + ADDR_W'(1);
                end
                WRITE: begin
                    // Pointers wrap silently at the top of the address space.
                    dst_ptr   <= dst_ptr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Mode;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [7:0] Len;
    logic [7:0] FillValue;
    logic [7:0] MemAddress;
    logic       MemWriteEn;
    logic [7:0] MemDataIn;
    logic [7:0] MemDataOut;
    logic       Busy;
    logic       Done;

    logic [7:0] mem [0:255];
    int         n_cmp;
    int         n_err;
    int         wr_log [$];

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Mode       (Mode),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Len        (Len),
        .FillValue  (FillValue),
        .MemAddress (MemAddress),
        .MemWriteEn (MemWriteEn),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut),
        .Busy       (Busy),
        .Done       (Done)
    );

    assign MemDataOut = mem[MemAddress];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Applies any write on the port, then moves to the next cycle sample point.
    task automatic tick();
        if (MemWriteEn) mem[MemAddress] = MemDataIn;
        @(posedge Clk);
        #1;
    endtask

    // Presents a request that is accepted at edge 0, then scrambles the inputs
    // so that only latched values can produce the expected result.
    task automatic launch(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f);
        @(negedge Clk);
        Mode = m; SrcAddr = s; DstAddr = d; Len = l; FillValue = f; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0; Mode = ~m; SrcAddr = 8'h55; DstAddr = 8'h66; Len = 8'h07; FillValue = 8'h99;
    endtask

    // Runs from cycle 1 until Done (left at the Done cycle) or the budget expires.
    task automatic run_xfer(input int budget, input int pulse_at,
                            output int done_cyc, output int nwr, output int nbusy);
        done_cyc = -1; nwr = 0; nbusy = 0;
        wr_log.delete();
        for (int c = 1; c <= budget; c++) begin
            if (Done) begin
                done_cyc = c;
                break;
            end
            if (Busy) nbusy++;
            if (MemWriteEn) begin
                wr_log.push_back(c);
                nwr++;
            end
            Start = (c == pulse_at);
            tick();
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (MemAddress !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", MemAddress); end
        n_cmp++; if (MemWriteEn !== 1'b0)  begin n_err++; $display("FAIL reset_we got %b want 0", MemWriteEn); end
        n_cmp++; if (MemDataIn !== 8'h00)  begin n_err++; $display("FAIL reset_din got %h want 00", MemDataIn); end
        n_cmp++; if (Busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy got %b want 0", Busy); end
        n_cmp++; if (Done !== 1'b0)        begin n_err++; $display("FAIL reset_done got %b want 0", Done); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_copy();
        int dc, nw, nb;
        logic [7:0] exp_b [4];
        exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        clear_mem();
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = exp_b[i];
        launch(1'b0, 8'h10, 8'h80, 8'd4, 8'h00);
        n_cmp++; if (MemAddress !== 8'h10 || MemWriteEn !== 1'b0 || Busy !== 1'b1) begin
            n_err++; $display("FAIL copy_first_read got addr %h we %b busy %b want 10 0 1", MemAddress, MemWriteEn, Busy);
        end
        run_xfer(40, 0, dc, nw, nb);
        n_cmp++; if (dc !== 9) begin n_err++; $display("FAIL copy_done_cycle got %0d want 9", dc); end
        n_cmp++; if (nw !== 4) begin n_err++; $display("FAIL copy_writes got %0d want 4", nw); end
        n_cmp++; if (nb !== 8) begin n_err++; $display("FAIL copy_busy_cycles got %0d want 8", nb); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= wr_log.size() || wr_log[k] !== 2 * k + 2) begin
                n_err++; $display("FAIL copy_write_cycle k=%0d got %0d want %0d", k, (k < wr_log.size()) ? wr_log[k] : -1, 2 * k + 2);
            end
            n_cmp++;
            if (mem[8'h80 + k] !== exp_b[k]) begin
                n_err++; $display("FAIL copy_data k=%0d got %h want %h", k, mem[8'h80 + k], exp_b[k]);
            end
        end
        n_cmp++; if (Busy !== 1'b0 || MemWriteEn !== 1'b0 || MemAddress !== 8'h00 || MemDataIn !== 8'h00) begin
            n_err++; $display("FAIL copy_done_outputs got busy %b we %b addr %h din %h want 0 0 00 00", Busy, MemWriteEn, MemAddress, MemDataIn);
        end
        tick();
        n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL copy_done_pulse got %b want 0", Done); end
    endtask

    task automatic test_fill_wrap();
        int dc, nw, nb;
        clear_mem();
        mem[8'h01] = 8'h77;
        launch(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A);
        run_xfer(20, 0, dc, nw, nb);
        n_cmp++; if (dc !== 4) begin n_err++; $display("FAIL fill_done_cycle got %0d want 4", dc); end
        n_cmp++; if (nw !== 3 || nb !== 3) begin n_err++; $display("FAIL fill_counts got wr %0d busy %0d want 3 3", nw, nb); end
        n_cmp++; if (mem[8'hFE] !== 8'h5A || mem[8'hFF] !== 8'h5A || mem[8'h00] !== 8'h5A) begin
            n_err++; $display("FAIL fill_data got %h %h %h want 5a 5a 5a", mem[8'hFE], mem[8'hFF], mem[8'h00]);
        end
        n_cmp++; if (mem[8'h01] !== 8'h77) begin n_err++; $display("FAIL fill_untouched got %h want 77", mem[8'h01]); end
        tick();
    endtask

    task automatic test_len_zero();
        int dc, nw, nb;
        launch(1'b0, 8'h10, 8'h80, 8'd0, 8'h00);
        run_xfer(10, 0, dc, nw, nb);
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL len0_done_cycle got %0d want 1", dc); end
        n_cmp++; if (nw !== 0 || nb !== 0 || MemWriteEn !== 1'b0 || Busy !== 1'b0) begin
            n_err++; $display("FAIL len0_activity got wr %0d busy %0d we %b busy_now %b want 0 0 0 0", nw, nb, MemWriteEn, Busy);
        end
        tick();
    endtask

    task automatic test_overlap();
        int dc, nw, nb;
        clear_mem();
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03;
        launch(1'b0, 8'h20, 8'h21, 8'd2, 8'h00);
        run_xfer(20, 0, dc, nw, nb);
        n_cmp++; if (dc !== 5) begin n_err++; $display("FAIL overlap_done_cycle got %0d want 5", dc); end
        n_cmp++; if (mem[8'h21] !== 8'h01 || mem[8'h22] !== 8'h01) begin
            n_err++; $display("FAIL overlap_data got %h %h want 01 01", mem[8'h21], mem[8'h22]);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int dc, nw, nb, extra_done, extra_wr;
        clear_mem();
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 8'h30 + 8'(i);
        launch(1'b0, 8'h10, 8'h90, 8'd4, 8'h00);
        run_xfer(40, 3, dc, nw, nb);
        extra_done = 0; extra_wr = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Done) extra_done++;
            if (MemWriteEn) extra_wr++;
        end
        n_cmp++; if (dc !== 9 || nw !== 4) begin n_err++; $display("FAIL busy_start_xfer got done %0d wr %0d want 9 4", dc, nw); end
        n_cmp++; if (extra_done !== 0 || extra_wr !== 0) begin
            n_err++; $display("FAIL busy_start_second got done %0d wr %0d want 0 0", extra_done, extra_wr);
        end
        n_cmp++; if (mem[8'h93] !== 8'h33 || mem[8'h66] !== 8'h00) begin
            n_err++; $display("FAIL busy_start_data got %h %h want 33 00", mem[8'h93], mem[8'h66]);
        end
    endtask

    task automatic test_reset_mid();
        int dc, nw, nb, dones;
        clear_mem();
        for (int i = 0; i < 8; i++) mem[8'h10 + i] = 8'hE0 + 8'(i);
        launch(1'b0, 8'h10, 8'hA0, 8'd8, 8'h00);
        for (int c = 1; c < 6; c++) tick();
        n_cmp++; if (MemWriteEn !== 1'b1 || MemAddress !== 8'hA2) begin
            n_err++; $display("FAIL rst_mid_third_write got we %b addr %h want 1 a2", MemWriteEn, MemAddress);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_cmp++; if (MemWriteEn !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_outputs got we %b busy %b done %b want 0 0 0", MemWriteEn, Busy, Done);
        end
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Done || Busy) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
        n_cmp++; if (mem[8'hA0] !== 8'hE0 || mem[8'hA1] !== 8'hE1 || mem[8'hA2] !== 8'h00) begin
            n_err++; $display("FAIL rst_mid_data got %h %h %h want e0 e1 00", mem[8'hA0], mem[8'hA1], mem[8'hA2]);
        end
        launch(1'b1, 8'h00, 8'h40, 8'd2, 8'h3C);
        run_xfer(20, 0, dc, nw, nb);
        n_cmp++; if (dc !== 3 || mem[8'h40] !== 8'h3C || mem[8'h41] !== 8'h3C) begin
            n_err++; $display("FAIL rst_mid_restart got done %0d data %h %h want 3 3c 3c", dc, mem[8'h40], mem[8'h41]);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0;
        SrcAddr = 8'h00; DstAddr = 8'h00; Len = 8'h00; FillValue = 8'h00;
        clear_mem();
        test_reset();
        test_copy();
        test_fill_wrap();
        test_len_zero();
        test_overlap();
        test_start_while_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
